// File: rtl/go_counter.sv
// Start/stop step counter with an internal prescaler, up/down and one-shot/loop modes,
// hold, abort, busy flag and a one-cycle done pulse on each arrival at the terminal value.
module go_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int TICK_DIV  = 1500000,
    parameter int DIV_WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             stop,
    input  logic             hold,
    input  logic             mode_down,
    input  logic             mode_loop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]     LP_MAX      = WIDTH'(MAX_COUNT);
    localparam logic [DIV_WIDTH-1:0] LP_DIV_LAST = DIV_WIDTH'(TICK_DIV - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_count;
    logic [DIV_WIDTH-1:0] r_presc;
    logic                 r_down;
    logic                 r_loop;
    logic                 r_done;

    state_t               w_nextState;
    logic [WIDTH-1:0]     w_nextCount;
    logic [DIV_WIDTH-1:0] w_nextPresc;
    logic                 w_nextDown;
    logic                 w_nextLoop;
    logic                 w_nextDone;
    logic [WIDTH-1:0]     w_start;
    logic [WIDTH-1:0]     w_term;
    logic [WIDTH-1:0]     w_stepped;

    assign w_start = r_down ? LP_MAX : '0;
    assign w_term  = r_down ? '0 : LP_MAX;

    // Leaving HOLD with hold low behaves exactly like a RUN cycle, so each held cycle costs one cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextPresc = r_presc;
        w_nextDown  = r_down;
        w_nextLoop  = r_loop;
        w_nextDone  = 1'b0;
        w_stepped   = r_count;

        case (r_state)
            IDLE: begin
                if (go && !stop) begin
                    w_nextState = RUN;
                    w_nextDown  = mode_down;
                    w_nextLoop  = mode_loop;
                    w_nextCount = mode_down ? LP_MAX : '0;
                    w_nextPresc = '0;
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    w_nextState = IDLE;
                end else if (hold) begin
                    w_nextState = HOLD;
                end else begin
                    w_nextState = RUN;
                    if (r_presc == LP_DIV_LAST) begin
                        w_nextPresc = '0;
                        if (r_count == w_term) begin
                            w_nextCount = w_start;
                        end else begin
                            w_stepped   = r_down ? (r_count - 1'b1) : (r_count + 1'b1);
                            w_nextCount = w_stepped;
                            if (w_stepped == w_term) begin
                                w_nextDone = 1'b1;
                                if (!r_loop) begin
                                    w_nextState = IDLE;
                                end
                            end
                        end
                    end else begin
                        w_nextPresc = r_presc + 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_down  <= 1'b0;
            r_loop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_presc <= w_nextPresc;
            r_down  <= w_nextDown;
            r_loop  <= w_nextLoop;
            r_done  <= w_nextDone;
        end
    end

    assign count = r_count;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;

endmodule

// File: tb/tb_go_counter.sv
// Bench for go_counter: two instances (slow prescaler and step-every-cycle) share stimulus and are
// compared each cycle against an elapsed-time arithmetic model of the counter.
module tb_go_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0;
    logic       stop = 1'b0;
    logic       hold = 1'b0;
    logic       mode_down = 1'b0;
    logic       mode_loop = 1'b0;
    logic [3:0] countA;
    logic [3:0] countB;
    logic       busyA;
    logic       busyB;
    logic       doneA;
    logic       doneB;

    int checks = 0;
    int failures = 0;
    int cycleNo = 0;
    int goCycle = 0;
    int lastDoneA = -1000;
    int lastDoneB = -1000;
    int savedDone = 0;

    int mMax[2] = '{5, 15};
    int mTd[2]  = '{3, 1};
    bit mBusy[2];
    bit mDown[2];
    bit mLoop[2];
    bit mDone[2];
    int mElapsed[2];
    int mCount[2];

    go_counter #(.WIDTH(4), .MAX_COUNT(5), .TICK_DIV(3), .DIV_WIDTH(4)) dutA (
        .clk(clk), .rst(rst), .go(go), .stop(stop), .hold(hold),
        .mode_down(mode_down), .mode_loop(mode_loop),
        .count(countA), .busy(busyA), .done(doneA)
    );

    go_counter #(.WIDTH(4), .MAX_COUNT(15), .TICK_DIV(1), .DIV_WIDTH(4)) dutB (
        .clk(clk), .rst(rst), .go(go), .stop(stop), .hold(hold),
        .mode_down(mode_down), .mode_loop(mode_loop),
        .count(countB), .busy(busyB), .done(doneB)
    );

    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count and done follow from how many unheld RUN cycles have elapsed since go was accepted.
    task automatic modelEdge(input int i);
        int steps;
        int pos;
        if (rst) begin
            mBusy[i] = 0; mDown[i] = 0; mLoop[i] = 0; mDone[i] = 0;
            mElapsed[i] = 0; mCount[i] = 0;
            return;
        end
        mDone[i] = 0;
        if (!mBusy[i]) begin
            if (go && !stop) begin
                mBusy[i] = 1; mDown[i] = mode_down; mLoop[i] = mode_loop;
                mElapsed[i] = 0;
                mCount[i] = mode_down ? mMax[i] : 0;
            end
        end else if (stop) begin
            mBusy[i] = 0;
        end else if (!hold) begin
            mElapsed[i]++;
            if (mElapsed[i] % mTd[i] == 0) begin
                steps = mElapsed[i] / mTd[i];
                pos = mLoop[i] ? steps % (mMax[i] + 1) : steps;
                mCount[i] = mDown[i] ? mMax[i] - pos : pos;
                if (pos == mMax[i]) begin
                    mDone[i] = 1;
                    if (!mLoop[i]) mBusy[i] = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkOne("A.count", 32'(countA), 32'(mCount[0]));
        checkOne("A.busy",  32'(busyA),  32'(mBusy[0]));
        checkOne("A.done",  32'(doneA),  32'(mDone[0]));
        checkOne("B.count", 32'(countB), 32'(mCount[1]));
        checkOne("B.busy",  32'(busyB),  32'(mBusy[1]));
        checkOne("B.done",  32'(doneB),  32'(mDone[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        cycleNo++;
        #1;
        checkOutput();
        if (doneA === 1'b1) lastDoneA = cycleNo;
        if (doneB === 1'b1) lastDoneB = cycleNo;
    endtask

    task automatic applyStimulus(input logic g, input logic s, input logic h,
                                 input logic md, input logic ml);
        go = g; stop = s; hold = h; mode_down = md; mode_loop = ml;
    endtask

    initial begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOne("reset.countA", 32'(countA), 0);
        checkOne("reset.busyA", 32'(busyA), 0);
        cycle();

        // Up, one-shot: both instances arrive after 15 cycles
        applyStimulus(1, 0, 0, 0, 0);
        cycle();
        goCycle = cycleNo;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (20) cycle();
        checkOne("s1.doneLatA", 32'(lastDoneA - goCycle), 15);
        checkOne("s1.doneLatB", 32'(lastDoneB - goCycle), 15);
        checkOne("s1.holdA", 32'(countA), 5);

        // Down, loop, then stop
        applyStimulus(1, 0, 0, 1, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (40) cycle();
        applyStimulus(0, 1, 0, 0, 0);
        cycle();
        checkOne("s2.stopBusyA", 32'(busyA), 0);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (5) cycle();

        // Hold for 10 cycles at count=2, prescaler=1
        applyStimulus(1, 0, 0, 0, 0);
        cycle();
        goCycle = cycleNo;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (7) cycle();
        applyStimulus(0, 0, 1, 0, 0);
        repeat (10) cycle();
        checkOne("s3.holdCountA", 32'(countA), 2);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (25) cycle();
        checkOne("s3.doneLatA", 32'(lastDoneA - goCycle), 25);

        // go with stop in IDLE, go and mode toggles during RUN
        applyStimulus(1, 1, 0, 1, 0);
        cycle();
        checkOne("s4.goStopBusyA", 32'(busyA), 0);
        applyStimulus(1, 0, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 1, 1);
        repeat (4) cycle();
        applyStimulus(1, 0, 0, 1, 0);
        repeat (3) cycle();
        applyStimulus(0, 0, 0, 0, 1);
        repeat (20) cycle();

        // Reset mid-run at count=3
        applyStimulus(1, 0, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (9) cycle();
        checkOne("s5.preRstA", 32'(countA), 3);
        savedDone = lastDoneA;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOne("s5.rstCountA", 32'(countA), 0);
        repeat (20) cycle();
        checkOne("s5.noDoneA", 32'(lastDoneA), 32'(savedDone));

        // Step-every-cycle loop on B, stopped after wrapping twice
        applyStimulus(1, 0, 0, 0, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (40) cycle();
        applyStimulus(0, 1, 0, 0, 0);
        cycle();

        // Randomized stimulus
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(99) == 0);
            go        = ($urandom_range(7) == 0);
            stop      = ($urandom_range(24) == 0);
            hold      = ($urandom_range(5) == 0);
            mode_down = 1'($urandom_range(1));
            mode_loop = 1'($urandom_range(1));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
